// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the three-way RAM port arbiter.
// The top honours the optional MEM_ARB_FWD_EN build macro for same-bundle store-to-load forwarding.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 8;
  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_D0    = 2'd2,
    OWN_D1    = 2'd3
  } owner_t;

  // Owner of the read data returning next cycle; stores return nothing.
  // A forwarded d1 load rides with a d0 store and is served from the forward register instead.
  function automatic owner_t read_owner(input logic gnt_f, input logic gnt_d0,
                                        input logic gnt_d1, input logic we_d0,
                                        input logic we_d1);
    owner_t own;
    own = OWN_NONE;
    if (gnt_d0) begin
      own = we_d0 ? OWN_NONE : OWN_D0;
    end else if (gnt_d1) begin
      own = we_d1 ? OWN_NONE : OWN_D1;
    end else if (gnt_f) begin
      own = OWN_FETCH;
    end
    return own;
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; starve_hit forces fetch to win.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic fetch_req,
  input  logic fetch_gnt,
  output logic starve_hit
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!fetch_req || fetch_gnt) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_hit = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for fetch and the two issue slots (d0 > d1 > fetch, anti-starvation).
// Build macro MEM_ARB_FWD_EN enables same-bundle d0-store to d1-load forwarding.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              d0_req,
  input  logic              d0_we,
  input  logic [ADDR_W-1:0] d0_addr,
  input  logic [DATA_W-1:0] d0_wdata,
  output logic              d0_gnt,
  output logic              d0_rvalid,
  output logic [DATA_W-1:0] d0_rdata,
  input  logic              d1_req,
  input  logic              d1_we,
  input  logic [ADDR_W-1:0] d1_addr,
  input  logic [DATA_W-1:0] d1_wdata,
  output logic              d1_gnt,
  output logic              d1_rvalid,
  output logic [DATA_W-1:0] d1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bundle_stall
);

  logic   starve_hit;
  logic   fetch_force;
  owner_t rd_owner_q;
  owner_t rd_owner_d;
  logic [1:0] slot_req;
  logic [1:0] slot_gnt;
  logic [1:0] slot_wait;

`ifdef MEM_ARB_FWD_EN
  logic              fwd_hit;
  logic              fwd_valid_q;
  logic [DATA_W-1:0] fwd_data_q;
`endif

  mem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_gnt  (fetch_gnt),
    .starve_hit (starve_hit)
  );

  assign fetch_force = fetch_req & starve_hit;

  // d1 is only considered when d0 is idle, which keeps p0's access ahead of p1's.
  always_comb begin
    fetch_gnt = 1'b0;
    d0_gnt    = 1'b0;
    d1_gnt    = 1'b0;
`ifdef MEM_ARB_FWD_EN
    fwd_hit   = 1'b0;
`endif
    if (!reset) begin
      if (fetch_force) begin
        fetch_gnt = 1'b1;
      end else if (d0_req) begin
        d0_gnt = 1'b1;
`ifdef MEM_ARB_FWD_EN
        if (d0_we && d1_req && !d1_we && (d0_addr == d1_addr)) begin
          d1_gnt  = 1'b1;
          fwd_hit = 1'b1;
        end
`endif
      end else if (d1_req) begin
        d1_gnt = 1'b1;
      end else if (fetch_req) begin
        fetch_gnt = 1'b1;
      end
    end
  end

  // In the forwarding case d0 owns the RAM port; d1 is served from fwd_data_q.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (d0_gnt) begin
      mem_addr  = d0_addr;
      mem_we    = d0_we;
      mem_wdata = d0_wdata;
    end else if (d1_gnt) begin
      mem_addr  = d1_addr;
      mem_we    = d1_we;
      mem_wdata = d1_wdata;
    end else if (fetch_gnt) begin
      mem_addr  = fetch_addr;
    end
  end

  assign rd_owner_d = read_owner(fetch_gnt, d0_gnt, d1_gnt, d0_we, d1_we);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner_q <= OWN_NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

`ifdef MEM_ARB_FWD_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
    end else begin
      fwd_valid_q <= fwd_hit;
      if (fwd_hit) begin
        fwd_data_q <= d0_wdata;
      end
    end
  end

  assign d1_rvalid = ~reset & ((rd_owner_q == OWN_D1) | fwd_valid_q);
  assign d1_rdata  = fwd_valid_q ? fwd_data_q : mem_rdata;
`else
  assign d1_rvalid = ~reset & (rd_owner_q == OWN_D1);
  assign d1_rdata  = mem_rdata;
`endif

  assign fetch_rvalid = ~reset & (rd_owner_q == OWN_FETCH);
  assign d0_rvalid    = ~reset & (rd_owner_q == OWN_D0);
  assign fetch_rdata  = mem_rdata;
  assign d0_rdata     = mem_rdata;

  assign slot_req = {d1_req, d0_req};
  assign slot_gnt = {d1_gnt, d0_gnt};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot_wait
      assign slot_wait[gi] = slot_req[gi] & ~slot_gnt[gi];
    end
  endgenerate

  assign bundle_stall = ~reset & (|slot_wait);

endmodule
